// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Sequential unsigned restoring divider, one quotient bit per
//             clock, with a start/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [1:0]    c_idle = 2'd0;
   localparam logic [1:0]    c_run  = 2'd1;
   localparam logic [1:0]    c_done = 2'd2;
   localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_p;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_div;
   logic [CW-1:0]    r_cnt;

   logic [WIDTH:0]   w_t;
   logic [WIDTH:0]   w_diff;
   logic             w_ge;
   logic [WIDTH-1:0] w_p_next;
   logic [WIDTH-1:0] w_q_next;

   // The partial remainder always stays below the divisor, so T < 2*divisor:
   // the borrow bit of T - divisor is exactly the complement of T >= divisor.
   always_comb begin
      w_t      = {r_p, r_q[WIDTH-1]};
      w_diff   = w_t - {1'b0, r_div};
      w_ge     = ~w_diff[WIDTH];
      w_p_next = w_ge ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];
      w_q_next = {r_q[WIDTH-2:0], w_ge};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= c_idle;
         r_p         <= '0;
         r_q         <= '0;
         r_div       <= '0;
         r_cnt       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (r_state)
            c_idle: begin
               if (start) begin
                  busy <= 1'b1;
                  if (divisor != '0) begin
                     r_q         <= dividend;
                     r_div       <= divisor;
                     r_p         <= '0;
                     r_cnt       <= '0;
                     div_by_zero <= 1'b0;
                     r_state     <= c_run;
                  end else begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     r_state     <= c_done;
                  end
               end
            end
            c_run: begin
               r_p   <= w_p_next;
               r_q   <= w_q_next;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == c_last) begin
                  quotient  <= w_q_next;
                  remainder <= w_p_next;
                  done      <= 1'b1;
                  r_state   <= c_done;
               end
            end
            c_done: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= c_idle;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= c_idle;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Scoreboard bench for seq_divider at WIDTH=4 and WIDTH=8.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_divider;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start4 = 1'b0, start8 = 1'b0;
   logic [3:0] a4 = '0, d4 = '0;
   logic [7:0] a8 = '0, d8 = '0;
   logic       busy4, done4, z4, busy8, done8, z8;
   logic [3:0] q4o, r4o;
   logic [7:0] q8o, r8o;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] q;
      logic [7:0] r;
      logic       z;
   } exp_t;

   exp_t sb4[$];
   exp_t sb8[$];
   exp_t e4, e8;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .dividend(a4), .divisor(d4),
      .busy(busy4), .done(done4), .quotient(q4o), .remainder(r4o),
      .div_by_zero(z4)
   );

   seq_divider #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .dividend(a8), .divisor(d8),
      .busy(busy8), .done(done8), .quotient(q8o), .remainder(r8o),
      .div_by_zero(z8)
   );

   function automatic exp_t model(input bit w8, input logic [7:0] a, input logic [7:0] d);
      exp_t e;
      e.a = a;
      e.d = d;
      if (d == 8'd0) begin
         e.q = w8 ? 8'hFF : 8'h0F;
         e.r = a;
         e.z = 1'b1;
      end else begin
         e.q = a / d;
         e.r = a % d;
         e.z = 1'b0;
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitors: pop the oldest expectation whenever a done pulse is seen
   always @(negedge clk) begin
      if (done4 === 1'b1) begin
         if (sb4.size() == 0) chk("unexpected_done4", 32'd1, 32'd0);
         else begin
            e4 = sb4.pop_front();
            chk("q4", {28'd0, q4o}, {24'd0, e4.q});
            chk("r4", {28'd0, r4o}, {24'd0, e4.r});
            chk("z4", {31'd0, z4}, {31'd0, e4.z});
            if (!e4.z)
               chk("mul4", 32'(q4o) * 32'(e4.d) + 32'(r4o), 32'(e4.a));
         end
      end
   end

   always @(negedge clk) begin
      if (done8 === 1'b1) begin
         if (sb8.size() == 0) chk("unexpected_done8", 32'd1, 32'd0);
         else begin
            e8 = sb8.pop_front();
            chk("q8", {24'd0, q8o}, {24'd0, e8.q});
            chk("r8", {24'd0, r8o}, {24'd0, e8.r});
            chk("z8", {31'd0, z8}, {31'd0, e8.z});
            if (!e8.z)
               chk("mul8", 32'(q8o) * 32'(e8.d) + 32'(r8o), 32'(e8.a));
         end
      end
   end

   // Issue one divide and check handshake timing; results go to the monitors
   task automatic run(input bit w8, input logic [7:0] a, input logic [7:0] d);
      int n;
      int lat;
      @(negedge clk);
      if (w8) begin
         start8 = 1'b1; a8 = a; d8 = d;
         sb8.push_back(model(1'b1, a, d));
      end else begin
         start4 = 1'b1; a4 = a[3:0]; d4 = d[3:0];
         sb4.push_back(model(1'b0, {4'd0, a[3:0]}, {4'd0, d[3:0]}));
      end
      @(posedge clk);
      #1;
      start4 = 1'b0;
      start8 = 1'b0;
      lat = (d == 8'd0) ? 1 : (w8 ? 9 : 5);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) chk("busy_rise", {31'd0, (w8 ? busy8 : busy4)}, 32'd1);
      end while (!(w8 ? done8 : done4) && n < 40);
      chk("latency", n, lat);
      @(negedge clk);
      chk("idle_after_done", {30'd0, (w8 ? busy8 : busy4), (w8 ? done8 : done4)}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      n_bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int n_done;
      logic [7:0] ra, rd;

      repeat (2) @(negedge clk);
      chk("reset_out4", {q4o, r4o, busy4, done4, z4}, 32'd0);
      chk("reset_out8", {q8o, r8o, busy8, done8, z8}, 32'd0);
      rst = 1'b0;

      run(1'b0, 8'd13, 8'd3);
      repeat (10) @(negedge clk);
      chk("held_q", {28'd0, q4o}, 32'd4);
      chk("held_r", {28'd0, r4o}, 32'd1);
      chk("held_z", {31'd0, z4}, 32'd0);

      run(1'b0, 8'd15, 8'd1);
      run(1'b0, 8'd7,  8'd9);
      run(1'b0, 8'd0,  8'd5);
      run(1'b0, 8'd15, 8'd15);
      run(1'b0, 8'd9,  8'd0);
      run(1'b0, 8'd6,  8'd2);

      // Asynchronous reset mid-RUN: outputs clear at once, no done follows
      @(negedge clk);
      start4 = 1'b1; a4 = 4'd13; d4 = 4'd5;
      @(posedge clk);
      #1 start4 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out", {q4o, r4o, busy4, done4, z4}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (done4) n_done++;
      end
      chk("no_done_after_rst", n_done, 0);
      run(1'b0, 8'd11, 8'd2);

      // Start held high with operands scrambled while the divide runs
      @(negedge clk);
      start4 = 1'b1; a4 = 4'd14; d4 = 4'd4;
      sb4.push_back(model(1'b0, 8'd14, 8'd4));
      @(posedge clk);
      n_done = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (done4) n_done++;
         if (k < 6) begin
            a4 = 4'($urandom);
            d4 = 4'($urandom);
         end else begin
            chk("held_idle_busy", {31'd0, busy4}, 32'd0);
            a4 = 4'd10; d4 = 4'd3;
            sb4.push_back(model(1'b0, 8'd10, 8'd3));
         end
      end
      chk("held_one_done", n_done, 1);
      @(negedge clk);
      chk("held_reaccept", {31'd0, busy4}, 32'd1);
      start4 = 1'b0;
      n = 0;
      while (!done4 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("held_second_done", {31'd0, done4}, 32'd1);
      @(negedge clk);

      for (int a = 0; a < 16; a++)
         for (int d = 0; d < 16; d++)
            run(1'b0, 8'(a), 8'(d));

      run(1'b1, 8'd255, 8'd1);
      run(1'b1, 8'd255, 8'd255);
      run(1'b1, 8'd0,   8'd0);
      run(1'b1, 8'd200, 8'd0);
      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom);
         rd = ($urandom_range(9, 0) == 0) ? 8'd0 : 8'($urandom);
         run(1'b1, ra, rd);
      end

      repeat (3) @(negedge clk);
      chk("sb4_drained", sb4.size(), 0);
      chk("sb8_drained", sb8.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
